// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: parameter
// legality and group generate/propagate reduction.
package cla_pkg;

    localparam int MAX_BLOCK = 64;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic bit params_legal(input int width, input int block);
        return (block >= 1) && (block <= MAX_BLOCK) && (width >= block) &&
               (width % block == 0);
    endfunction

    // Reduce the low n bit-level g/p pairs into one group generate/propagate.
    function automatic gp_t group_gp(input logic [MAX_BLOCK-1:0] g,
                                     input logic [MAX_BLOCK-1:0] p,
                                     input int n);
        gp_t r;
        r.g = 1'b0;
        r.p = 1'b1;
        for (int i = 0; i < MAX_BLOCK; i++) begin
            if (i < n) begin
                r.g = g[i] | (p[i] & r.g);
                r.p = r.p & p[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational BLOCK-bit lookahead group: every internal carry is formed
// directly from cin and a prefix generate/propagate, not rippled.
module cla_group
    import cla_pkg::*;
#(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             g,
    output logic             p,
    output logic             cout,
    output logic             c_msb_in
);

    logic [BLOCK-1:0] bit_g;
    logic [BLOCK-1:0] bit_p;
    logic [BLOCK:0]   c;
    gp_t              pre;
    gp_t              grp;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    always_comb begin
        pre  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            pre      = group_gp(MAX_BLOCK'(bit_g), MAX_BLOCK'(bit_p), i + 1);
            c[i+1]   = pre.g | (pre.p & cin);
        end
    end

    assign grp      = group_gp(MAX_BLOCK'(bit_g), MAX_BLOCK'(bit_p), BLOCK);
    assign g        = grp.g;
    assign p        = grp.p;
    assign sum      = bit_p ^ c[BLOCK-1:0];
    assign cout     = c[BLOCK];
    assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one lookahead group resolved per stage, with a
// valid/ready chain that collapses bubbles and streams at full rate.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NUM_STAGES = WIDTH / BLOCK;

    if (!params_legal(WIDTH, BLOCK)) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
    end

    logic [NUM_STAGES-1:0] vld;
    logic [NUM_STAGES:0]   rdy;
    logic [WIDTH-1:0]      a_p   [NUM_STAGES];
    logic [WIDTH-1:0]      b_p   [NUM_STAGES];
    logic [WIDTH-1:0]      sum_p [NUM_STAGES];
    logic [NUM_STAGES-1:0] c_p;
    logic [NUM_STAGES-1:0] cmsb_p;
    logic [WIDTH-1:0]      b_eff;
    logic                  c0;

    // Subtraction folds into addition: A + ~B + ~borrow.
    assign b_eff = in_sub ? ~in_b : in_b;
    assign c0    = in_sub ? ~in_cin : in_cin;

    assign rdy[NUM_STAGES] = out_ready;
    assign in_ready        = rdy[0];

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        logic             vin;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic [WIDTH-1:0] sum_next;
        logic             c_in;
        logic [BLOCK-1:0] grp_sum;
        logic             grp_g;
        logic             grp_p;
        logic             grp_cout;
        logic             grp_cmsb;

        if (s == 0) begin : g_first
            assign vin    = in_valid;
            assign a_in   = in_a;
            assign b_in   = b_eff;
            assign sum_in = '0;
            assign c_in   = c0;
        end else begin : g_next
            assign vin    = vld[s-1];
            assign a_in   = a_p[s-1];
            assign b_in   = b_p[s-1];
            assign sum_in = sum_p[s-1];
            assign c_in   = c_p[s-1];
        end

        cla_group #(.BLOCK(BLOCK)) u_group (
            .a        (a_in[s*BLOCK +: BLOCK]),
            .b        (b_in[s*BLOCK +: BLOCK]),
            .cin      (c_in),
            .sum      (grp_sum),
            .g        (grp_g),
            .p        (grp_p),
            .cout     (grp_cout),
            .c_msb_in (grp_cmsb)
        );

        always_comb begin
            sum_next                     = sum_in;
            sum_next[s*BLOCK +: BLOCK]   = grp_sum;
            assert (grp_cout == (grp_g | (grp_p & c_in)));
        end

        assign rdy[s] = !vld[s] | rdy[s+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld[s] <= 1'b0;
            end else if (rdy[s]) begin
                vld[s] <= vin;
            end
        end

        // Stage boundary: data registers load only on a real transfer.
        always_ff @(posedge clk) begin
            if (rdy[s] && vin) begin
                a_p[s]    <= a_in;
                b_p[s]    <= b_in;
                sum_p[s]  <= sum_next;
                c_p[s]    <= grp_cout;
                cmsb_p[s] <= grp_cmsb;
            end
        end
    end

    assign out_valid = vld[NUM_STAGES-1];
    assign out_sum   = out_valid ? sum_p[NUM_STAGES-1] : '0;
    assign out_cout  = out_valid & c_p[NUM_STAGES-1];
    assign out_ovf   = out_valid & (cmsb_p[NUM_STAGES-1] ^ c_p[NUM_STAGES-1]);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed cases, backpressure,
// mid-stream reset on the default build, plus three parameter-sweep builds.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          occ      = 0;
    int          cyc      = 0;
    bit          chk_lat  = 1'b1;
    logic [65:0] exp_q[$];
    int          cyc_q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference result packed as {ovf, cout, sum[63:0]} for a w-bit adder.
    function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub, input int w);
        logic [63:0] mask, aa, bb, s;
        logic [64:0] full;
        logic        c;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa   = a & mask;
        bb   = (sub ? ~b : b) & mask;
        c    = sub ? ~cin : cin;
        full = {1'b0, aa} + {1'b0, bb} + 65'(c);
        s    = full[63:0] & mask;
        return {(aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]), full[w], s};
    endfunction

    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic ordy, output logic acc);
        logic [65:0] e;
        int          lat;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = ordy;
        #1;
        check("in_ready", 96'(in_ready), 96'(!(occ == 4 && !ordy)));
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 96'(1), 96'(0));
            end else begin
                e   = exp_q.pop_front();
                lat = cyc - cyc_q.pop_front();
                check("result", 96'({out_ovf, out_cout, 64'(out_sum)}), 96'(e));
                if (chk_lat) check("latency", 96'(lat), 96'(4));
                occ--;
            end
        end
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back(ref_add(64'(a), 64'(b), cin, sub, 16));
            cyc_q.push_back(cyc);
            occ++;
        end
        cyc++;
    endtask

    task automatic send_one(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub);
        logic acc;
        cycle(1'b1, a, b, cin, sub, 1'b1, acc);
        check("accept", 96'(acc), 96'(1));
        repeat (5) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
        check("drained", 96'(exp_q.size()), 96'(0));
    endtask

    task automatic reset_pulse(input int ncyc);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'h1111;
        in_b      = 16'h2222;
        out_ready = 1'b1;
        repeat (ncyc - 1) @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_out_sum",   96'(out_sum),   96'(0));
        check("rst_out_cout",  96'(out_cout),  96'(0));
        check("rst_out_ovf",   96'(out_ovf),   96'(0));
        check("rst_in_ready",  96'(in_ready),  96'(1));
        exp_q.delete();
        cyc_q.delete();
        occ = 0;
        cyc++;
    endtask

    for (genvar g = 0; g < 3; g++) begin : sweep
        localparam int W = (g == 0) ? 8 : (g == 1) ? 32 : 12;
        localparam int B = (g == 0) ? 8 : (g == 1) ? 4 : 3;

        logic         srst, sv, sir, so, svo, sco, sov, scin, ssub;
        logic [W-1:0] sa, sb, ss;
        bit           done = 1'b0;

        pipelined_cla_adder #(.WIDTH(W), .BLOCK(B)) dut (
            .clk       (clk),
            .rst       (srst),
            .in_valid  (sv),
            .in_ready  (sir),
            .in_a      (sa),
            .in_b      (sb),
            .in_cin    (scin),
            .in_sub    (ssub),
            .out_valid (svo),
            .out_ready (so),
            .out_sum   (ss),
            .out_cout  (sco),
            .out_ovf   (sov)
        );

        initial begin : drive
            logic [65:0] q[$];
            int          cq[$];
            int          scyc;
            int          sent;
            logic [65:0] e;
            srst = 1'b1; sv = 1'b0; so = 1'b1; sa = '0; sb = '0; scin = 1'b0; ssub = 1'b0;
            scyc = 0;
            sent = 0;
            repeat (2) @(negedge clk);
            srst = 1'b0;
            while ((sent < 1000 || q.size() != 0) && scyc < 1200) begin
                @(negedge clk);
                sv   = (sent < 1000);
                sa   = W'($urandom);
                sb   = W'($urandom);
                scin = 1'($urandom);
                ssub = 1'($urandom);
                #1;
                if (svo) begin
                    if (q.size() == 0) begin
                        check($sformatf("sw%0d_unexpected", W), 96'(1), 96'(0));
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sw%0d_result", W), 96'({sov, sco, 64'(ss)}), 96'(e));
                        check($sformatf("sw%0d_latency", W), 96'(scyc - cq.pop_front()), 96'(W / B));
                    end
                end
                if (sv && sir) begin
                    q.push_back(ref_add(64'(sa), 64'(sb), scin, ssub, W));
                    cq.push_back(scyc);
                    sent++;
                end
                scyc++;
            end
            check($sformatf("sw%0d_drain", W), 96'({sent == 1000, q.size() == 0}), 96'(2'b11));
            done = 1'b1;
        end
    end

    initial begin
        logic        acc;
        logic [15:0] ba, bb;
        logic        bc, bs;
        int          sent;
        int          waited;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        reset_pulse(3);

        send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send_one(16'h0005, 16'h0007, 1'b0, 1'b1);
        send_one(16'h8000, 16'h0001, 1'b0, 1'b1);
        send_one(16'h0010, 16'h0003, 1'b1, 1'b1);
        send_one(16'h1234, 16'hEDCB, 1'b1, 1'b0);

        // Backpressure stream: data held until accepted.
        chk_lat = 1'b0;
        sent = 0;
        ba = 16'($urandom); bb = 16'($urandom); bc = 1'($urandom); bs = 1'($urandom);
        for (int i = 0; i < 300 && (sent < 10 || exp_q.size() != 0); i++) begin
            cycle(sent < 10, ba, bb, bc, bs, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                sent++;
                ba = 16'($urandom); bb = 16'($urandom); bc = 1'($urandom); bs = 1'($urandom);
            end
        end
        check("bp_drain", 96'({sent == 10, exp_q.size() == 0}), 96'(2'b11));

        // Mid-stream reset with three beats in flight.
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'(16'h0100 + i), 16'h0001, 1'b0, 1'b0, 1'b0, acc);
            check("mid_accept", 96'(acc), 96'(1));
        end
        reset_pulse(1);
        repeat (6) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
        send_one(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);

        waited = 0;
        while (!(sweep[0].done && sweep[1].done && sweep[2].done) && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("sweep_done", 96'({sweep[0].done, sweep[1].done, sweep[2].done}), 96'(3'b111));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
